// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS32 memory-access stage.
// Load/store op codes, FSM states and the data-memory command payload.
package mem_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BE_W     = XLEN / 8;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned WB_SRC_W = 2;

  typedef enum logic [OP_W-1:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Per-access command presented on the data-memory bus.
  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dmem_cmd_t;

  function automatic logic op_is_load(logic [OP_W-1:0] op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
           (op == MEM_OP_LHU) || (op == MEM_OP_LW);
  endfunction

  function automatic logic op_is_store(logic [OP_W-1:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage and the data memory.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] wdata;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store replication/byte enables, load extraction
// and sign/zero extension, plus alignment checking.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic            is_mem_c,
  output logic            is_store_c,
  output logic            misaligned_c,
  output dmem_cmd_t       cmd_c,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Little-endian lane select from the read word.
  always_comb begin
    rd_byte = rdata[{addr_lo, 3'b000} +: 8];
    rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    is_store_c   = op_is_store(op);
    is_mem_c     = op_is_load(op) | is_store_c;
    misaligned_c = 1'b0;
    cmd_c        = '0;
    load_data_c  = '0;
    if (op_is_load(op)) begin
      cmd_c.be = '1;
    end
    case (op)
      MEM_OP_LB:  load_data_c = {{24{rd_byte[7]}}, rd_byte};
      MEM_OP_LBU: load_data_c = {24'h0, rd_byte};
      MEM_OP_LH: begin
        misaligned_c = addr_lo[0];
        load_data_c  = {{16{rd_half[15]}}, rd_half};
      end
      MEM_OP_LHU: begin
        misaligned_c = addr_lo[0];
        load_data_c  = {16'h0, rd_half};
      end
      MEM_OP_LW: begin
        misaligned_c = |addr_lo;
        load_data_c  = rdata;
      end
      MEM_OP_SB: begin
        cmd_c.we    = 1'b1;
        cmd_c.wdata = {4{store_data[7:0]}};
        cmd_c.be    = BE_W'(4'b0001) << addr_lo;
      end
      MEM_OP_SH: begin
        misaligned_c = addr_lo[0];
        cmd_c.we     = 1'b1;
        cmd_c.wdata  = {2{store_data[15:0]}};
        cmd_c.be     = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      MEM_OP_SW: begin
        misaligned_c = |addr_lo;
        cmd_c.we     = 1'b1;
        cmd_c.wdata  = store_data;
        cmd_c.be     = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: issues byte-enabled req/ack accesses, stalls the
// upstream pipeline while an access is outstanding and bubbles mem_wb meanwhile.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     ex_alu_result,
  input  logic [XLEN-1:0]     ex_store_data,
  input  logic [OP_W-1:0]     ex_mem_op,
  input  logic                ex_reg_wr,
  input  logic [REG_AW-1:0]   ex_waddr,
  input  logic [WB_SRC_W-1:0] ex_reg_wb_src,
  output logic [XLEN-1:0]     mem_mem_data,
  output logic [XLEN-1:0]     mem_alu_result,
  output logic                mem_reg_wr,
  output logic [REG_AW-1:0]   mem_waddr,
  output logic [WB_SRC_W-1:0] mem_reg_wb_src,
  output logic                mem_stall,
  output logic                mem_addr_err,
  output logic                mem_bus_err,
  mem_stage_if.master         dmem
);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            abort_q, abort_d;

  logic            is_mem, is_store, misaligned;
  dmem_cmd_t       cmd;
  logic [XLEN-1:0] load_data;
  logic            req, stall, reg_wr, addr_err, bus_err;
  logic            timeout_hit;

  mem_align u_align (
    .op           (ex_mem_op),
    .addr_lo      (ex_alu_result[1:0]),
    .store_data   (ex_store_data),
    .rdata        (dmem.rdata),
    .is_mem_c     (is_mem),
    .is_store_c   (is_store),
    .misaligned_c (misaligned),
    .cmd_c        (cmd),
    .load_data_c  (load_data)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      abort_q <= abort_d;
    end
  end

  // Next state, capture and control; reset gates everything visible.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    abort_d  = abort_q;
    req      = 1'b0;
    stall    = 1'b0;
    reg_wr   = ex_reg_wr;
    addr_err = 1'b0;
    bus_err  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (is_mem && misaligned) begin
          addr_err = 1'b1;
          reg_wr   = 1'b0;
        end else if (is_mem) begin
          req    = 1'b1;
          stall  = 1'b1;
          reg_wr = 1'b0;
          if (dmem.ack) begin
            if (!is_store) begin
              data_d = load_data;
            end
            state_d = ST_DONE;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        stall  = 1'b1;
        reg_wr = 1'b0;
        if (timeout_hit) begin
          bus_err = 1'b1;
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          req   = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (dmem.ack) begin
            if (!is_store) begin
              data_d = load_data;
            end
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        reg_wr  = ex_reg_wr & ~abort_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      req      = 1'b0;
      stall    = 1'b0;
      reg_wr   = 1'b0;
      addr_err = 1'b0;
      bus_err  = 1'b0;
    end
  end

  assign mem_mem_data   = rst ? '0 : data_q;
  assign mem_alu_result = ex_alu_result;
  assign mem_reg_wr     = reg_wr;
  assign mem_waddr      = ex_waddr;
  assign mem_reg_wb_src = ex_reg_wb_src;
  assign mem_stall      = stall;
  assign mem_addr_err   = addr_err;
  assign mem_bus_err    = bus_err;

  assign dmem.req   = req;
  assign dmem.we    = req & cmd.we;
  assign dmem.addr  = {ex_alu_result[XLEN-1:2], 2'b00};
  assign dmem.be    = cmd.be;
  assign dmem.wdata = cmd.wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases then random transactions against an
// arithmetic model of lane selection, extension, stall length and timeout.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [3:0]  ex_mem_op;
  logic        ex_reg_wr;
  logic [4:0]  ex_waddr;
  logic [1:0]  ex_reg_wb_src;
  logic [31:0] mem_mem_data, mem_alu_result;
  logic        mem_reg_wr, mem_stall, mem_addr_err, mem_bus_err;
  logic [4:0]  mem_waddr;
  logic [1:0]  mem_reg_wb_src;

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_mem_op      (ex_mem_op),
    .ex_reg_wr      (ex_reg_wr),
    .ex_waddr       (ex_waddr),
    .ex_reg_wb_src  (ex_reg_wb_src),
    .mem_mem_data   (mem_mem_data),
    .mem_alu_result (mem_alu_result),
    .mem_reg_wr     (mem_reg_wr),
    .mem_waddr      (mem_waddr),
    .mem_reg_wb_src (mem_reg_wb_src),
    .mem_stall      (mem_stall),
    .mem_addr_err   (mem_addr_err),
    .mem_bus_err    (mem_bus_err),
    .dmem           (dmem)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: access size, lanes and extension by plain arithmetic.
  function automatic bit m_load(logic [3:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
  endfunction

  function automatic bit m_store(logic [3:0] op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
  endfunction

  function automatic int unsigned m_size(logic [3:0] op);
    if (op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH}) return 2;
    if (op inside {MEM_OP_LW, MEM_OP_SW}) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] m_load_val(logic [3:0] op, logic [31:0] a, logic [31:0] rd);
    int unsigned sh = 8 * (a % 4);
    logic [31:0] v;
    case (op)
      MEM_OP_LB, MEM_OP_LBU: begin
        v = (rd >> sh) & 32'hFF;
        if (op == MEM_OP_LB && v >= 128) v = v + 32'hFFFF_FF00;
      end
      MEM_OP_LH, MEM_OP_LHU: begin
        v = (rd >> sh) & 32'hFFFF;
        if (op == MEM_OP_LH && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_be(logic [3:0] op, logic [31:0] a);
    if (op == MEM_OP_SB) return 32'd1 << (a % 4);
    if (op == MEM_OP_SH) return 32'd3 << (a % 4);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(logic [3:0] op, logic [31:0] d);
    if (op == MEM_OP_SB) return (d & 32'hFF) * 32'h0101_0101;
    if (op == MEM_OP_SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One instruction through the stage; ack_k = request cycle index carrying ack.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic rw, input logic [4:0] wa, input logic [1:0] src,
                         input int ack_k, input logic [31:0] rd);
    int k;
    bit acked, aborted;
    @(posedge clk); #1;
    ex_mem_op = op; ex_alu_result = a; ex_store_data = sd;
    ex_reg_wr = rw; ex_waddr = wa; ex_reg_wb_src = src;
    dmem.ack = 1'b0; dmem.rdata = $urandom;
    if (!(m_load(op) || m_store(op)) || (a % m_size(op)) != 0) begin
      dmem.ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("pass_stall", mem_stall, 0);
      check("pass_req", dmem.req, 0);
      check("pass_addr_err", mem_addr_err, (m_load(op) || m_store(op)) ? 1 : 0);
      check("pass_reg_wr", mem_reg_wr, (m_load(op) || m_store(op)) ? 0 : rw);
      check("pass_waddr", mem_waddr, wa);
      check("pass_alu", mem_alu_result, a);
      check("pass_src", mem_reg_wb_src, src);
      check("pass_data", mem_mem_data, model_data);
      return;
    end
    k = 0; acked = 0; aborted = 0;
    while (!acked && !aborted) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k <= int'(TO)) begin
        dmem.ack   = (k == ack_k);
        dmem.rdata = (k == ack_k) ? rd : $urandom;
        @(negedge clk);
        check("req", dmem.req, 1);
        check("stall", mem_stall, 1);
        check("bubble", mem_reg_wr, 0);
        check("we", dmem.we, m_store(op) ? 1 : 0);
        check("be", dmem.be, m_be(op, a));
        check("addr", dmem.addr, a & 32'hFFFF_FFFC);
        if (m_store(op)) check("wdata", dmem.wdata, m_wdata(op, sd));
        check("hold_data", mem_mem_data, model_data);
        check("no_bus_err", mem_bus_err, 0);
        if (k == ack_k) acked = 1;
      end else begin
        dmem.ack = 1'b0;
        @(negedge clk);
        check("abort_req", dmem.req, 0);
        check("abort_stall", mem_stall, 1);
        check("bus_err", mem_bus_err, 1);
        aborted = 1;
      end
      k++;
    end
    if (acked && m_load(op)) model_data = m_load_val(op, a, rd);
    @(posedge clk); #1;
    dmem.ack = 1'($urandom_range(0, 1)); dmem.rdata = $urandom;
    @(negedge clk);
    check("done_stall", mem_stall, 0);
    check("done_req", dmem.req, 0);
    check("done_reg_wr", mem_reg_wr, aborted ? 0 : rw);
    check("done_data", mem_mem_data, model_data);
    check("done_bus_err", mem_bus_err, 0);
    check("done_waddr", mem_waddr, wa);
  endtask

  initial begin
    model_data = '0;
    rst = 1'b1;
    ex_mem_op = MEM_OP_LW; ex_alu_result = 32'h100; ex_store_data = '0;
    ex_reg_wr = 1'b1; ex_waddr = 5'd3; ex_reg_wb_src = 2'd1;
    dmem.ack = 1'b0; dmem.rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", dmem.req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_reg_wr", mem_reg_wr, 0);
    check("rst_addr_err", mem_addr_err, 0);
    check("rst_bus_err", mem_bus_err, 0);
    check("rst_data", mem_mem_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ex_mem_op = MEM_OP_NONE;

    // Directed cases
    run_txn(MEM_OP_NONE, 32'h1234, 32'h0, 1'b1, 5'd5, 2'd0, 0, 32'h0);
    run_txn(MEM_OP_LB, 32'h103, 32'h0, 1'b1, 5'd7, 2'd1, 2, 32'h80FF_FF7F);
    check("lb_const", mem_mem_data, 32'hFFFF_FF80);
    run_txn(MEM_OP_LBU, 32'h103, 32'h0, 1'b1, 5'd7, 2'd1, 1, 32'h80FF_FF7F);
    check("lbu_const", mem_mem_data, 32'h0000_0080);
    run_txn(MEM_OP_SH, 32'h202, 32'hABCD_1234, 1'b0, 5'd0, 2'd0, 0, 32'h0);
    run_txn(MEM_OP_LW, 32'h101, 32'h0, 1'b1, 5'd9, 2'd1, 0, 32'h0);
    run_txn(MEM_OP_LW, 32'h400, 32'h0, 1'b1, 5'd9, 2'd1, 99, 32'h0);
    check("timeout_keeps_data", mem_mem_data, 32'h0000_0080);

    // Reset while an access is outstanding
    @(posedge clk); #1;
    ex_mem_op = MEM_OP_LW; ex_alu_result = 32'h300; ex_reg_wr = 1'b1;
    dmem.ack = 1'b0;
    @(negedge clk);
    check("rw_req_idle", dmem.req, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_stall_wait", mem_stall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rw_req_in_rst", dmem.req, 0);
    check("rw_stall_in_rst", mem_stall, 0);
    @(posedge clk); #1;
    rst = 1'b0; model_data = '0;
    ex_mem_op = MEM_OP_NONE; ex_reg_wr = 1'b0;
    dmem.ack = 1'b1; dmem.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rw_req_after", dmem.req, 0);
    check("rw_stall_after", mem_stall, 0);
    check("rw_reg_wr_after", mem_reg_wr, 0);
    check("rw_data_after", mem_mem_data, 0);
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    @(negedge clk);
    check("rw_late_ack_ignored", mem_mem_data, 0);

    // Random transactions
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      op = 4'($urandom_range(0, 9));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(m_size(op) - 1);
      run_txn(op, a, $urandom, 1'($urandom_range(0, 1)), 5'($urandom), 2'($urandom),
              int'($urandom_range(0, TO + 2)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
